// File: rtl/writeback_state_if.sv
// Bus between the memory stage register / decode and the writeback stage.
// MEM_REG_VALID qualifies every MEM_* field in the same cycle; there is no ready, writeback accepts every valid cycle.
interface writeback_state_if #(
    parameter int CNT_WIDTH = 64
);
    logic                 MEM_REG_VALID;
    logic [31:0]          MEM_REG_IR;
    logic [31:0]          MEM_REG_DOUT2;
    logic [31:0]          MEM_REG_ALU_RESULT;
    logic [31:0]          MEM_REG_PC_4;
    logic [1:0]           MEM_RF_WR_SEL;
    logic                 MEM_REG_WRITE;
    logic [31:0]          WB_CSR_RD;
    logic [4:0]           DEC_RS1_ADDR;
    logic [4:0]           DEC_RS2_ADDR;
    logic [31:0]          WB_RS1_DATA;
    logic [31:0]          WB_RS2_DATA;
    logic                 WB_FWD_WE;
    logic [4:0]           WB_FWD_RD;
    logic [31:0]          WB_FWD_DATA;
    logic [CNT_WIDTH-1:0] WB_RETIRED;

    modport master (
        output MEM_REG_VALID, MEM_REG_IR, MEM_REG_DOUT2, MEM_REG_ALU_RESULT, MEM_REG_PC_4,
               MEM_RF_WR_SEL, MEM_REG_WRITE, WB_CSR_RD, DEC_RS1_ADDR, DEC_RS2_ADDR,
        input  WB_RS1_DATA, WB_RS2_DATA, WB_FWD_WE, WB_FWD_RD, WB_FWD_DATA, WB_RETIRED
    );

    modport slave (
        input  MEM_REG_VALID, MEM_REG_IR, MEM_REG_DOUT2, MEM_REG_ALU_RESULT, MEM_REG_PC_4,
               MEM_RF_WR_SEL, MEM_REG_WRITE, WB_CSR_RD, DEC_RS1_ADDR, DEC_RS2_ADDR,
        output WB_RS1_DATA, WB_RS2_DATA, WB_FWD_WE, WB_FWD_RD, WB_FWD_DATA, WB_RETIRED
    );
endinterface

// File: rtl/writeback_state.sv
// Writeback stage: load formatting, writeback source select, register file with
// write-through read ports, forwarding bus and retired-instruction counter.
module writeback_state #(
    parameter int CNT_WIDTH = 64,
    parameter bit RESET_RF  = 1'b1
) (
    input logic           WB_CLOCK,
    input logic           WB_RESET,
    writeback_state_if.slave wb
);
    logic [4:0]           rd;
    logic [2:0]           funct3;
    logic [1:0]           off;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          ld_data;
    logic [31:0]          wb_data;
    logic                 we;
    logic [31:0]          rs1_data;
    logic [31:0]          rs2_data;
    logic [31:0]          rf [0:31];
    logic [CNT_WIDTH-1:0] retired_q;

    assign rd     = wb.MEM_REG_IR[11:7];
    assign funct3 = wb.MEM_REG_IR[14:12];
    assign off    = wb.MEM_REG_ALU_RESULT[1:0];

    // DOUT2 is the raw aligned word; pick the lane, halfwords ignore off[0].
    always_comb begin
        ld_byte = wb.MEM_REG_DOUT2[7:0];
        case (off)
            2'd1:    ld_byte = wb.MEM_REG_DOUT2[15:8];
            2'd2:    ld_byte = wb.MEM_REG_DOUT2[23:16];
            2'd3:    ld_byte = wb.MEM_REG_DOUT2[31:24];
            default: ld_byte = wb.MEM_REG_DOUT2[7:0];
        endcase
        ld_half = off[1] ? wb.MEM_REG_DOUT2[31:16] : wb.MEM_REG_DOUT2[15:0];
        ld_data = wb.MEM_REG_DOUT2;
        case (funct3)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = wb.MEM_REG_DOUT2;
        endcase
    end

    always_comb begin
        wb_data = wb.MEM_REG_ALU_RESULT;
        case (wb.MEM_RF_WR_SEL)
            2'd0:    wb_data = wb.MEM_REG_PC_4;
            2'd1:    wb_data = wb.WB_CSR_RD;
            2'd2:    wb_data = ld_data;
            default: wb_data = wb.MEM_REG_ALU_RESULT;
        endcase
    end

    // Gating with WB_RESET blocks both the write and the bypass while reset is held.
    assign we = wb.MEM_REG_VALID & wb.MEM_REG_WRITE & (rd != 5'd0) & WB_RESET;

    generate
        if (RESET_RF) begin : g_rf_reset
            always_ff @(posedge WB_CLOCK or negedge WB_RESET) begin
                if (!WB_RESET) begin
                    for (int i = 0; i < 32; i++) rf[i] <= '0;
                end else if (we) begin
                    rf[rd] <= wb_data;
                end
            end
        end else begin : g_rf_keep
            always_ff @(posedge WB_CLOCK) begin
                if (we) rf[rd] <= wb_data;
            end
        end
    endgenerate

    always_comb begin
        rs1_data = rf[wb.DEC_RS1_ADDR];
        if (wb.DEC_RS1_ADDR == 5'd0)                rs1_data = '0;
        else if (we && (wb.DEC_RS1_ADDR == rd))     rs1_data = wb_data;
    end

    always_comb begin
        rs2_data = rf[wb.DEC_RS2_ADDR];
        if (wb.DEC_RS2_ADDR == 5'd0)                rs2_data = '0;
        else if (we && (wb.DEC_RS2_ADDR == rd))     rs2_data = wb_data;
    end

    // Every valid instruction retires, including ones that do not write rd.
    always_ff @(posedge WB_CLOCK or negedge WB_RESET) begin
        if (!WB_RESET) retired_q <= '0;
        else if (wb.MEM_REG_VALID) retired_q <= retired_q + CNT_WIDTH'(1);
    end

    assign wb.WB_RS1_DATA = rs1_data;
    assign wb.WB_RS2_DATA = rs2_data;
    assign wb.WB_FWD_WE   = we;
    assign wb.WB_FWD_RD   = rd;
    assign wb.WB_FWD_DATA = wb_data;
    assign wb.WB_RETIRED  = retired_q;
endmodule

// File: doc/writeback_state.md
Name: writeback_state

Overview:
- Final pipeline stage; sits directly downstream of the memory stage register.
- Formats load data from the memory stage by byte/halfword lane select and sign/zero extension.
- Selects the writeback source and writes the 32x32 register file, which it owns.
- Provides the two decode read ports with write-through bypass, plus a forwarding bus and a retired-instruction counter.

Parameters:
- CNT_WIDTH, 64, width of retired-instruction counter.
- RESET_RF, 1, 1 = async reset clears all registers; 0 = reset leaves register contents unchanged.

Ports:
- WB_CLOCK  in  1  stage clock; all state updates on posedge.
- WB_RESET  in  1  asynchronous, active-low reset.
- MEM_REG_VALID  in  1  memory stage register holds a real instruction.
- MEM_REG_IR  in  32  instruction word; rd = [11:7], funct3 = [14:12].
- MEM_REG_DOUT2  in  32  raw word read from word-aligned address (unshifted).
- MEM_REG_ALU_RESULT  in  32  ALU result / load address.
- MEM_REG_PC_4  in  32  PC+4 of the instruction.
- MEM_RF_WR_SEL  in  2  0 = PC+4, 1 = CSR_RD, 2 = formatted load, 3 = ALU result.
- MEM_REG_WRITE  in  1  instruction writes rd.
- WB_CSR_RD  in  32  CSR read data for RF_WR_SEL = 1.
- DEC_RS1_ADDR  in  5  decode read address 1.
- DEC_RS2_ADDR  in  5  decode read address 2.
- WB_RS1_DATA  out  32  register read data 1.
- WB_RS2_DATA  out  32  register read data 2.
- WB_FWD_WE  out  1  forwarding valid.
- WB_FWD_RD  out  5  forwarding destination.
- WB_FWD_DATA  out  32  forwarding data (selected writeback value).
- WB_RETIRED  out  CNT_WIDTH  count of retired instructions.

Behaviour:
- Load formatting (combinational):
  - off = ALU_RESULT[1:0].
  - funct3 0 (LB): sign-extend byte at DOUT2[8*off+7 : 8*off].
  - funct3 4 (LBU): zero-extend the same byte.
  - funct3 1 (LH): sign-extend half at DOUT2[16*off[1]+15 : 16*off[1]]; off[0] ignored, no trap.
  - funct3 5 (LHU): zero-extend the same half.
  - funct3 2 (LW) and any other funct3: DOUT2 unchanged.
- Writeback value wb_data = mux(RF_WR_SEL) per port list. Selection is a pure function of the current inputs; no extra latency.
- Write enable we = MEM_REG_VALID & MEM_REG_WRITE & (rd != 0) & WB_RESET.
- Register write: on posedge WB_CLOCK when we, rf[rd] <= wb_data. x0 is never written and always reads 0.
- Read ports (combinational):
  - WB_RSn_DATA = 0 if addr = 0.
  - Otherwise wb_data if we and addr = rd (write-through bypass, same cycle).
  - Otherwise rf[addr].
  - Both ports may hit the bypass simultaneously.
- Forwarding: WB_FWD_WE = we, WB_FWD_RD = rd, WB_FWD_DATA = wb_data. When WB_FWD_WE = 0, WB_FWD_RD and WB_FWD_DATA still show the decoded values; consumers ignore them.
- Retire counter:
  - Increments by 1 on every posedge where MEM_REG_VALID = 1, including stores and branches with REG_WRITE = 0.
  - Wraps from all-ones to 0 silently.
- Reset (WB_RESET = 0, asynchronous, any time including mid-write):
  - WB_RETIRED = 0 immediately.
  - If RESET_RF = 1, all rf entries = 0 immediately.
  - WB_FWD_WE = 0 while asserted; no register write occurs on a posedge while asserted.
  - Read ports return rf contents: 0 with RESET_RF = 1.
- Reset release: first write and counter increment occur on the first posedge with WB_RESET = 1.
- Simultaneous write to rd and read of same rd: the read returns the new value (bypass). The value is registered at the edge.

Test Plan:
- Reset, then MEM_REG_VALID = 1, REG_WRITE = 1, IR rd = 5, funct3 = 0, ALU_RESULT = 0x1003, DOUT2 = 0x80FF_1234, RF_WR_SEL = 2 -> WB_FWD_DATA = 0xFFFF_FF80; after posedge, DEC_RS1_ADDR = 5 reads 0xFFFF_FF80.
- Same with funct3 = 5, ALU_RESULT = 0x1002, DOUT2 = 0x80FF_1234 -> 0x0000_80FF. With funct3 = 1, ALU_RESULT = 0x1001 -> 0x0000_1234 (off[0] ignored).
- rd = 0, RF_WR_SEL = 3, ALU_RESULT = 0xDEAD_BEEF -> WB_FWD_WE = 0; DEC_RS2_ADDR = 0 reads 0 before and after the edge.
- rd = 7, RF_WR_SEL = 0, PC_4 = 0x0000_0104, DEC_RS1_ADDR = DEC_RS2_ADDR = 7 in the same cycle -> both read 0x0000_0104 before the edge (bypass) and after it.
- Ten valid instructions (4 with REG_WRITE = 0) plus 3 cycles with VALID = 0 -> WB_RETIRED = 10. With CNT_WIDTH = 4 and 17 valid cycles -> WB_RETIRED = 1 (wrap).
- Assert WB_RESET low mid-cycle with we = 1 for rd = 9 -> WB_RETIRED = 0 and rf[9] = 0 without waiting for a clock edge, no write at the next posedge, WB_FWD_WE = 0. Release -> first valid instruction writes normally.
